// File: rtl/lcd_stream_sequencer.sv
// lcd_stream_sequencer: parses the 17-bit display token stream through a 2-entry
// lookahead buffer and serves one RGB565 pixel per LCD request, filling on underflow.
module lcd_stream_sequencer #(
  parameter int FRAME_WIDTH = 480,
  parameter int FRAME_HEIGHT = 272,
  parameter logic [15:0] FILL_COLOR = 16'h0000
) (
  input  logic        screen_clk,
  input  logic        reset_n,
  input  logic [16:0] queue_data_in,
  input  logic        queue_empty,
  output logic        queue_rd_en,
  input  logic        lcd_frame_start,
  input  logic        pix_req,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_done,
  output logic        in_frame,
  output logic [15:0] underflow_cnt,
  output logic [7:0]  sync_err_cnt
);
  localparam int RW = $clog2(FRAME_HEIGHT + 1);
  localparam int CW = $clog2(FRAME_WIDTH);
  localparam logic [RW-1:0] H_L = RW'(FRAME_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(FRAME_WIDTH - 1);
  typedef enum logic [1:0] {SEEK, ROW_WAIT, PIXELS} state_t;
  state_t state, nxt;
  logic [16:0] b0, b1;
  logic [1:0] cnt;
  logic [RW-1:0] row, nrow;
  logic [CW-1:0] col, ncol;
  logic hv, is_fs, is_rs, is_fe, is_px, align_err, serve, pop, err, done;
  assign hv = cnt != 2'd0;
  assign is_fs = b0 == 17'h10000;
  assign is_rs = b0 == 17'h10001;
  assign is_fe = b0 == 17'h1FFFF;
  assign is_px = !b0[16];
  // The read lands at the edge that closes the cycle, so it only needs a free slot.
  assign queue_rd_en = reset_n && !queue_empty && cnt < 2'd2;
  assign align_err = lcd_frame_start && state != SEEK && (row != '0 || state == PIXELS);
  assign serve = pix_req && !align_err && state == PIXELS && hv && is_px;
  always_comb begin
    nxt = state;
    nrow = row;
    ncol = col;
    pop = 1'b0;
    err = 1'b0;
    done = 1'b0;
    if (align_err) begin
      nxt = SEEK;
      err = 1'b1;
    end else if (hv) begin
      case (state)
        SEEK: begin
          pop = 1'b1;
          nrow = '0;
          nxt = is_fs ? ROW_WAIT : SEEK;
        end
        ROW_WAIT: begin
          pop = 1'b1;
          if (is_rs && row < H_L) begin
            nxt = PIXELS;
            ncol = '0;
          end else if (is_fe && row == H_L) begin
            nxt = SEEK;
            done = 1'b1;
          end else begin
            err = 1'b1;
            nrow = '0;
            nxt = is_fs ? ROW_WAIT : SEEK;
          end
        end
        PIXELS: begin
          if (!is_px) begin
            pop = 1'b1;
            err = 1'b1;
            nrow = '0;
            nxt = is_fs ? ROW_WAIT : SEEK;
          end else if (pix_req) begin
            pop = 1'b1;
            ncol = col == C_LAST ? '0 : col + 1'b1;
            nrow = col == C_LAST ? row + 1'b1 : row;
            nxt = col == C_LAST ? ROW_WAIT : PIXELS;
          end
        end
        default: nxt = SEEK;
      endcase
    end
  end
  always_ff @(posedge screen_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEEK;
      row <= '0;
      col <= '0;
      b0 <= '0;
      b1 <= '0;
      cnt <= 2'd0;
      pix_data <= FILL_COLOR;
      pix_valid <= 1'b0;
      frame_done <= 1'b0;
      in_frame <= 1'b0;
      underflow_cnt <= '0;
      sync_err_cnt <= '0;
    end else begin
      state <= nxt;
      row <= nrow;
      col <= ncol;
      in_frame <= nxt != SEEK;
      frame_done <= done;
      if (err && sync_err_cnt != 8'hFF) sync_err_cnt <= sync_err_cnt + 1'b1;
      if (pix_req) begin
        pix_data <= serve ? b0[15:0] : FILL_COLOR;
        pix_valid <= serve;
        if (!serve && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 1'b1;
      end
      // A push never coincides with a full buffer, so pop+push only happens at occupancy 1.
      if (pop) b0 <= cnt == 2'd2 ? b1 : queue_data_in;
      else if (queue_rd_en && cnt == 2'd0) b0 <= queue_data_in;
      if (queue_rd_en && cnt != 2'd0 && !pop) b1 <= queue_data_in;
      cnt <= cnt + {1'b0, queue_rd_en} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_lcd_stream_sequencer.sv
// tb_lcd_stream_sequencer: directed scenarios with a scoreboard queue of expected
// pixel responses, drained by an independent monitor process.
module tb_lcd_stream_sequencer;
  localparam int W = 23;
  localparam int H = 17;
  localparam logic [15:0] FILL = 16'hF81F;
  logic screen_clk = 1'b0;
  logic reset_n = 1'b0;
  logic lcd_frame_start = 1'b0;
  logic pix_req = 1'b0;
  logic queue_empty, queue_rd_en, pix_valid, frame_done, in_frame;
  logic [16:0] queue_data_in;
  logic [15:0] pix_data, underflow_cnt;
  logic [7:0] sync_err_cnt;
  logic [16:0] mem [0:16383];
  int wr = 0;
  int rd = 0;
  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [16:0] exp_q[$];

  lcd_stream_sequencer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .FILL_COLOR(FILL)) dut (
    .screen_clk(screen_clk),
    .reset_n(reset_n),
    .queue_data_in(queue_data_in),
    .queue_empty(queue_empty),
    .queue_rd_en(queue_rd_en),
    .lcd_frame_start(lcd_frame_start),
    .pix_req(pix_req),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .frame_done(frame_done),
    .in_frame(in_frame),
    .underflow_cnt(underflow_cnt),
    .sync_err_cnt(sync_err_cnt)
  );

  always #5 screen_clk = ~screen_clk;

  // Show-ahead FIFO model: head word is visible, pop advances at the read edge.
  assign queue_empty = rd == wr;
  assign queue_data_in = mem[rd[13:0]];
  always @(posedge screen_clk) if (queue_rd_en) rd <= rd + 1;

  always @(posedge screen_clk) begin : monitor
    logic req_s;
    logic [16:0] e;
    req_s = reset_n && pix_req;
    #1;
    if (frame_done) fd_cnt++;
    if (req_s) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel unexpected: got valid=%b data=%h with empty scoreboard", pix_valid, pix_data);
      end else begin
        e = exp_q.pop_front();
        if ({pix_valid, pix_data} !== e) begin
          errors++;
          $display("FAIL pixel: got valid=%b data=%h want valid=%b data=%h", pix_valid, pix_data, e[16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge screen_clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] pv(input int f, input int r, input int c);
    int v;
    v = f * 7919 + r * 331 + c * 97 + (r << 11);
    return v[15:0];
  endfunction

  task automatic push(input logic [16:0] w);
    mem[wr[13:0]] = w;
    wr++;
  endtask

  task automatic push_row(input int f, input int r, input int n);
    push(17'h10001);
    for (int c = 0; c < n; c++) push({1'b0, pv(f, r, c)});
  endtask

  task automatic load_frame(input int f);
    push(17'h10000);
    for (int r = 0; r < H; r++) push_row(f, r, W);
    push(17'h1FFFF);
  endtask

  task automatic req(input logic [16:0] e);
    pix_req = 1'b1;
    exp_q.push_back(e);
    tick();
    pix_req = 1'b0;
  endtask

  task automatic row_reqs(input int f, input int r, input int n);
    for (int c = 0; c < n; c++) req({1'b1, pv(f, r, c)});
    tick(3);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pix_req = 1'b0;
    lcd_frame_start = 1'b0;
    #1;
    check("reset pix_data", pix_data, FILL);
    check("reset pix_valid", pix_valid, 0);
    check("reset frame_done", frame_done, 0);
    check("reset in_frame", in_frame, 0);
    check("reset underflow_cnt", underflow_cnt, 0);
    check("reset sync_err_cnt", sync_err_cnt, 0);
    check("reset queue_rd_en", queue_rd_en, 0);
    tick(2);
    wr = rd;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic clean_frame(input int f, input logic [15:0] ufl, input logic [7:0] serr);
    int fd0;
    fd0 = fd_cnt;
    lcd_frame_start = 1'b1;
    tick();
    lcd_frame_start = 1'b0;
    load_frame(f);
    tick(6);
    for (int r = 0; r < H; r++) row_reqs(f, r, W);
    tick(4);
    check("frame_done pulses", fd_cnt - fd0, 1);
    check("frame underflow_cnt", underflow_cnt, ufl);
    check("frame sync_err_cnt", sync_err_cnt, serr);
    check("frame fifo empty", queue_empty, 1);
    check("frame in_frame", in_frame, 0);
    check("scoreboard drained", exp_q.size(), 0);
  endtask

  initial begin
    int fd0;
    tick();
    do_reset();
    clean_frame(1, 16'd0, 8'd0);
    // Underflow on an empty FIFO, then normal delivery resumes.
    do_reset();
    repeat (5) req({1'b0, FILL});
    tick();
    check("underflow count 5", underflow_cnt, 5);
    clean_frame(2, 16'd5, 8'd0);
    // Short row: row 3 cut to 20 pixels, trailing garbage before the next frame.
    do_reset();
    push(17'h10000);
    for (int r = 0; r < 3; r++) push_row(3, r, W);
    push_row(3, 3, 20);
    push_row(3, 4, W);
    tick(6);
    for (int r = 0; r < 3; r++) row_reqs(3, r, W);
    for (int c = 0; c < 20; c++) req({1'b1, pv(3, 3, c)});
    tick(40);
    check("short row sync_err_cnt", sync_err_cnt, 1);
    check("short row in_frame", in_frame, 0);
    check("short row garbage discarded", queue_empty, 1);
    clean_frame(4, 16'd0, 8'd1);
    // Early FRAME_START inside row 1 restarts the frame immediately.
    do_reset();
    fd0 = fd_cnt;
    push(17'h10000);
    push_row(5, 0, W);
    push_row(5, 1, 10);
    load_frame(6);
    tick(6);
    row_reqs(5, 0, W);
    for (int c = 0; c < 10; c++) req({1'b1, pv(5, 1, c)});
    tick(3);
    for (int r = 0; r < H; r++) row_reqs(6, r, W);
    tick(4);
    check("early fs sync_err_cnt", sync_err_cnt, 1);
    check("early fs frame_done", fd_cnt - fd0, 1);
    check("early fs underflow_cnt", underflow_cnt, 0);
    // Display resync at row 5 with a simultaneous request.
    do_reset();
    fd0 = fd_cnt;
    load_frame(7);
    tick(6);
    for (int r = 0; r < 5; r++) row_reqs(7, r, W);
    lcd_frame_start = 1'b1;
    req({1'b0, FILL});
    lcd_frame_start = 1'b0;
    check("resync sync_err_cnt", sync_err_cnt, 1);
    check("resync in_frame", in_frame, 0);
    tick(400);
    check("resync no frame_done", fd_cnt - fd0, 0);
    check("resync underflow_cnt", underflow_cnt, 1);
    clean_frame(8, 16'd1, 8'd1);
    // Reset mid-row.
    do_reset();
    repeat (2) req({1'b0, FILL});
    load_frame(9);
    tick(6);
    for (int c = 0; c < 10; c++) req({1'b1, pv(9, 0, c)});
    tick();
    check("pre-reset underflow_cnt", underflow_cnt, 2);
    check("pre-reset in_frame", in_frame, 1);
    do_reset();
    clean_frame(10, 16'd0, 8'd0);
    // Underflow counter saturation.
    do_reset();
    for (int i = 0; i < 70000; i++) req({1'b0, FILL});
    tick();
    check("underflow saturation", underflow_cnt, 16'hFFFF);
    check("final scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
